// File: rtl/button_debounce_multi.sv
// ---------------------------------------------------------------------------
// button_debounce_multi
//
// Multi-channel push-button conditioner. Each channel is independent:
// raw level -> 2-flop synchronizer -> stability counter -> debounced state,
// with registered one-cycle press/release pulses and a per-channel press
// counter (wrapping or saturating).
//
// Parameters
//   NUM_CH          number of channels (1..32)
//   DEBOUNCE_CYCLES synchronized cycles a new level must hold (1..65535)
//   CNT_W           width of each press counter (1..16)
//   SATURATE        0: press counter wraps, 1: press counter holds at all-ones
//
// Ports
//   CLK             clock, rising edge
//   i_Rst_N         asynchronous active-low reset
//   i_Button_Raw    raw asynchronous button levels, 1 = pressed
//   i_Clear_Count   synchronous clear of every press counter (wins over a press)
//   o_Button_State  debounced level per channel
//   o_Press_Pulse   one-cycle pulse, coincident with an accepted 0->1
//   o_Release_Pulse one-cycle pulse, coincident with an accepted 1->0
//   o_Press_Count   channel n count at [n*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module button_debounce_multi #(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned SATURATE        = 0
) (
  input  logic                    CLK,
  input  logic                    i_Rst_N,
  input  logic [NUM_CH-1:0]       i_Button_Raw,
  input  logic                    i_Clear_Count,
  output logic [NUM_CH-1:0]       o_Button_State,
  output logic [NUM_CH-1:0]       o_Press_Pulse,
  output logic [NUM_CH-1:0]       o_Release_Pulse,
  output logic [NUM_CH*CNT_W-1:0] o_Press_Count
);

  // Stability counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int unsigned    StabW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [StabW-1:0] StabLast = StabW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

  // Elaboration-time parameter range checks.
  if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
    $error("NUM_CH out of range 1..32");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range 1..65535");
  end
  if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
    $error("CNT_W out of range 1..16");
  end
  if (SATURATE > 1) begin : g_bad_saturate
    $error("SATURATE must be 0 or 1");
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic             sync1_q;
    logic             sync2_q;
    logic [StabW-1:0] stab_q;
    logic [StabW-1:0] stab_d;
    logic             state_q;
    logic             state_d;
    logic             press_q;
    logic             press_d;
    logic             rel_q;
    logic             rel_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;

    always_comb begin
      accept  = 1'b0;
      stab_d  = '0;
      state_d = state_q;
      // Any cycle where the synchronized level matches the state restarts
      // the count, so only an unbroken run of DEBOUNCE_CYCLES is accepted.
      if (sync2_q != state_q) begin
        if (stab_q == StabLast) begin
          accept  = 1'b1;
          state_d = sync2_q;
        end else begin
          stab_d = stab_q + StabW'(1);
        end
      end

      // Pulses are registered alongside the state so they line up with it.
      press_d = accept & sync2_q;
      rel_d   = accept & ~sync2_q;

      cnt_d = cnt_q;
      if (i_Clear_Count) begin
        cnt_d = '0;
      end else if (press_d) begin
        if (SATURATE != 0 && cnt_q == CntMax) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge CLK or negedge i_Rst_N) begin
      if (!i_Rst_N) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        stab_q  <= '0;
        state_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= i_Button_Raw[ch];
        sync2_q <= sync1_q;
        stab_q  <= stab_d;
        state_q <= state_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        cnt_q   <= cnt_d;
      end
    end

    assign o_Button_State[ch]               = state_q;
    assign o_Press_Pulse[ch]                = press_q;
    assign o_Release_Pulse[ch]              = rel_q;
    assign o_Press_Count[ch*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Bench for button_debounce_multi: NUM_CH=2, DEBOUNCE_CYCLES=4, CNT_W=3.
// Two instances share all inputs, one wrapping and one saturating.
module tb_button_debounce_multi;

  logic       CLK;
  logic       rst_n;
  logic [1:0] raw;
  logic       clr;

  logic [1:0] st_w, pp_w, rp_w;
  logic [5:0] cnt_w;
  logic [1:0] st_s, pp_s, rp_s;
  logic [5:0] cnt_s;

  button_debounce_multi #(
    .NUM_CH(2), .DEBOUNCE_CYCLES(4), .CNT_W(3), .SATURATE(0)
  ) u_dut_wrap (
    .CLK(CLK), .i_Rst_N(rst_n), .i_Button_Raw(raw), .i_Clear_Count(clr),
    .o_Button_State(st_w), .o_Press_Pulse(pp_w), .o_Release_Pulse(rp_w),
    .o_Press_Count(cnt_w)
  );

  button_debounce_multi #(
    .NUM_CH(2), .DEBOUNCE_CYCLES(4), .CNT_W(3), .SATURATE(1)
  ) u_dut_sat (
    .CLK(CLK), .i_Rst_N(rst_n), .i_Button_Raw(raw), .i_Clear_Count(clr),
    .o_Button_State(st_s), .o_Press_Pulse(pp_s), .o_Release_Pulse(rp_s),
    .o_Press_Count(cnt_s)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int edge_cnt = 0;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  typedef struct {
    int         edge_no;
    logic [1:0] state;
    logic [1:0] press;
    logic [1:0] rel;
    logic [5:0] cw;
    logic [5:0] cs;
  } exp_t;

  exp_t exp_q[$];

  // Reference press counters.
  logic [2:0] m_w [2];
  logic [2:0] m_s [2];

  function automatic logic [2:0] inc_w(input logic [2:0] c);
    return c + 3'd1;
  endfunction

  function automatic logic [2:0] inc_s(input logic [2:0] c);
    return (c == 3'd7) ? c : c + 3'd1;
  endfunction

  // Expected pulse arrives on the 6th edge after the edge that precedes the
  // raw change (2 sync edges + 4 stable edges).
  task automatic push(input int e, input logic [1:0] st, input logic [1:0] pr,
                      input logic [1:0] rl);
    exp_t x;
    x.edge_no = e + 6;
    x.state   = st;
    x.press   = pr;
    x.rel     = rl;
    x.cw      = {m_w[1], m_w[0]};
    x.cs      = {m_s[1], m_s[0]};
    exp_q.push_back(x);
  endtask

  task automatic set_raw(input logic [1:0] v, output int e);
    @(posedge CLK);
    #2;
    raw = v;
    e   = edge_cnt;
  endtask

  // Monitor: every pulse on either instance must match the next expectation.
  exp_t mon_e;
  always @(negedge CLK) begin
    if ((pp_w | rp_w | pp_s | rp_s) != 2'b00) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: press=%b release=%b at edge %0d, expected none",
                 pp_w, rp_w, edge_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_edge", edge_cnt, mon_e.edge_no);
        chk("state_wrap", st_w, mon_e.state);
        chk("press_wrap", pp_w, mon_e.press);
        chk("release_wrap", rp_w, mon_e.rel);
        chk("count_wrap", cnt_w, mon_e.cw);
        chk("state_sat", st_s, mon_e.state);
        chk("press_sat", pp_s, mon_e.press);
        chk("release_sat", rp_s, mon_e.rel);
        chk("count_sat", cnt_s, mon_e.cs);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state_wrap"}, st_w, 0);
    chk({tag, "_press_wrap"}, pp_w, 0);
    chk({tag, "_release_wrap"}, rp_w, 0);
    chk({tag, "_count_wrap"}, cnt_w, 0);
    chk({tag, "_state_sat"}, st_s, 0);
    chk({tag, "_press_sat"}, pp_s, 0);
    chk({tag, "_release_sat"}, rp_s, 0);
    chk({tag, "_count_sat"}, cnt_s, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    for (int i = 0; i < 2; i++) begin
      m_w[i] = '0;
      m_s[i] = '0;
    end
    raw   = 2'b00;
    clr   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    @(posedge CLK);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge CLK);

    // Bounce on ch0: never stable for 4 synchronized cycles.
    @(posedge CLK);
    #2 raw[0] = 1'b1;
    #20 raw[0] = 1'b0;
    #15 raw[0] = 1'b1;
    #20 raw[0] = 1'b0;
    #60;
    repeat (8) @(posedge CLK);
    #1;
    chk("bounce_state", st_w[0], 0);
    chk("bounce_count", cnt_w[2:0], 0);

    // Clean press then release on ch0.
    set_raw(2'b01, e);
    m_w[0] = inc_w(m_w[0]);
    m_s[0] = inc_s(m_s[0]);
    push(e, 2'b01, 2'b01, 2'b00);
    repeat (10) @(posedge CLK);
    #1;
    chk("press_ch1_untouched", st_w[1], 0);
    set_raw(2'b00, e);
    push(e, 2'b00, 2'b00, 2'b01);
    repeat (10) @(posedge CLK);

    // Nine press/release pairs on ch1: wrap to 1, saturate at 7.
    for (int i = 0; i < 9; i++) begin
      set_raw(2'b10, e);
      m_w[1] = inc_w(m_w[1]);
      m_s[1] = inc_s(m_s[1]);
      push(e, 2'b10, 2'b10, 2'b00);
      repeat (8) @(posedge CLK);
      set_raw(2'b00, e);
      push(e, 2'b00, 2'b00, 2'b10);
      repeat (8) @(posedge CLK);
    end
    #1;
    chk("wrap_count1", cnt_w[5:3], 1);
    chk("sat_count1", cnt_s[5:3], 7);

    // Clear on the same edge that accepts a ch0 press: clear wins.
    set_raw(2'b01, e);
    for (int i = 0; i < 2; i++) begin
      m_w[i] = '0;
      m_s[i] = '0;
    end
    push(e, 2'b01, 2'b01, 2'b00);
    repeat (5) @(posedge CLK);
    #2 clr = 1'b1;
    @(posedge CLK);
    #2 clr = 1'b0;
    repeat (6) @(posedge CLK);
    set_raw(2'b00, e);
    push(e, 2'b00, 2'b00, 2'b01);
    repeat (10) @(posedge CLK);

    // Both channels change together.
    set_raw(2'b11, e);
    for (int i = 0; i < 2; i++) begin
      m_w[i] = inc_w(m_w[i]);
      m_s[i] = inc_s(m_s[i]);
    end
    push(e, 2'b11, 2'b11, 2'b00);
    repeat (10) @(posedge CLK);
    set_raw(2'b00, e);
    push(e, 2'b00, 2'b00, 2'b11);
    repeat (10) @(posedge CLK);

    // Reset in the middle of a ch0 press count.
    set_raw(2'b01, e);
    repeat (4) @(posedge CLK);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    for (int i = 0; i < 2; i++) begin
      m_w[i] = '0;
      m_s[i] = '0;
    end
    repeat (2) @(posedge CLK);
    #2 rst_n = 1'b1;
    e = edge_cnt;
    m_w[0] = inc_w(m_w[0]);
    m_s[0] = inc_s(m_s[0]);
    push(e, 2'b01, 2'b01, 2'b00);
    repeat (12) @(posedge CLK);
    #1;

    chk("pending_expectations", exp_q.size(), 0);
    chk("final_state", st_w, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
